// File: rtl/interrupt_controller_pkg.sv
// Shared interrupt map: MMIO register addresses, source bit indices and dispatch base.
// Timer, video, serial and joypad blocks index I_INT_SRC through these constants.
package interrupt_controller_pkg;

    localparam int          DEF_NUM_SRC  = 5;
    localparam logic [15:0] DEF_VEC_BASE = 16'h0040;

    localparam logic [15:0] MMIO_IF = 16'hFF0F;
    localparam logic [15:0] MMIO_IE = 16'hFFFF;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/int_priority_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module int_priority_enc #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pend,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        valid = |pend;
        index = '0;
        // Walk from the top down so the lowest set bit is the last to overwrite.
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE register pair on the MMIO bus plus the request/acknowledge handshake to the CPU.
// Bit 0 is the highest priority; source n dispatches to VEC_BASE + 8*n.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SRC  = DEF_NUM_SRC,
    parameter logic [15:0] VEC_BASE = DEF_VEC_BASE
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET,
    input  logic [15:0]        I_ADDR,
    inout  wire  [7:0]         IO_DATA,
    input  logic               I_RE_L,
    input  logic               I_WE_L,
    input  logic [NUM_SRC-1:0] I_INT_SRC,
    input  logic               I_IME,
    input  logic               I_INT_ACK,
    output logic               O_INT_REQ,
    output logic [15:0]        O_INT_VECTOR,
    output logic               O_WAKE
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] if_q, if_d, pend, ack_clr;
    logic [7:0]         ie_q, rd_data;
    logic               if_sel, ie_sel, if_we, ie_we, rd_en;
    logic               win_valid, take_ack;
    logic [IDX_W-1:0]   win_idx;
    logic [15:0]        win_vec, vec_q;
    irq_state_e         state, state_d;

    // ---------------- MMIO decode and read-back ----------------
    assign if_sel = (I_ADDR == MMIO_IF);
    assign ie_sel = (I_ADDR == MMIO_IE);
    assign if_we  = if_sel && !I_WE_L;
    assign ie_we  = ie_sel && !I_WE_L;
    assign rd_en  = (if_sel || ie_sel) && !I_RE_L;

    // Unimplemented IF bits read back as ones.
    assign rd_data = if_sel ? {{(8 - NUM_SRC){1'b1}}, if_q} : ie_q;
    assign IO_DATA = rd_en ? rd_data : {8{1'bz}};

    // ---------------- priority resolution ----------------
    assign pend = if_q & ie_q[NUM_SRC-1:0];

    int_priority_enc #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_prio (
        .pend  (pend),
        .valid (win_valid),
        .index (win_idx)
    );

    assign win_vec = VEC_BASE + 16'({win_idx, 3'b000});

    // ---------------- handshake FSM ----------------
    always_comb begin
        state_d  = state;
        take_ack = 1'b0;
        unique case (state)
            ST_IDLE: if (I_IME && win_valid) state_d = ST_REQ;
            ST_REQ: begin
                // A withdrawn request leaves IF untouched.
                if (!I_IME || !win_valid) begin
                    state_d = ST_IDLE;
                end else if (I_INT_ACK) begin
                    take_ack = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK:  if (!I_INT_ACK) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack_clr = take_ack ? (NUM_SRC'(1) << win_idx) : '0;

    // A new request pulse overrides both the bus write and the acknowledge clear.
    assign if_d = ((if_we ? IO_DATA[NUM_SRC-1:0] : if_q) & ~ack_clr) | I_INT_SRC;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state <= ST_IDLE;
            if_q  <= '0;
            ie_q  <= '0;
            vec_q <= VEC_BASE;
        end else begin
            state <= state_d;
            if_q  <= if_d;
            if (ie_we)    ie_q  <= IO_DATA;
            if (take_ack) vec_q <= win_vec;
        end
    end

    // ---------------- outputs ----------------
    assign O_INT_REQ    = (state == ST_REQ);
    assign O_INT_VECTOR = (state == ST_REQ) ? win_vec : vec_q;
    assign O_WAKE       = win_valid;

endmodule
